ab_stim_seq: RTL and testbench

- Upstream stimulus sequencer that drives the two 1-bit operands `a` and `b` into the downstream two-input stage.
- The downstream stage computes `c = a | b` over the pair.
- Generates a programmed number of operand pairs, either as an exhaustive 2-bit walk or as LFSR pseudo-random pairs.
- Hands each pair over with a valid/ready handshake and reports busy/done to the testbench controller.

---
 rtl/ab_stim_seq.sv | 121 ++++++++++++
 tb/tb_ab_stim_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ab_stim_seq.sv
// ab_stim_seq: upstream stimulus sequencer for a two-input (c = a | b) stage.
// It emits a programmed number of {a,b} operand pairs, either as a 2-bit
// walk (00,01,10,11,...) or taken from an 8-bit Fibonacci LFSR, and reports
// busy/done to the controller.
//
// Handshake: a transfer happens on every rising clock edge where valid=1 and
// ready=1. While valid=1 and ready=0, a, b, vec_cnt and the LFSR all hold.
// When valid=0, a and b keep their last values, so consumers must qualify
// them with valid.
module ab_stim_seq #(
  parameter int         COUNT_W   = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               mode,
  input  logic [COUNT_W-1:0] num_vec,
  input  logic               abort,
  input  logic               ready,
  output logic               a,
  output logic               b,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] vec_cnt,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 8'h01.
  localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  state_t             state;
  logic               mode_q;
  logic [COUNT_W-1:0] num_q;
  logic [7:0]         lfsr;
  logic               xfer;
  logic [COUNT_W-1:0] cnt_inc;
  logic [7:0]         lfsr_nxt;

  // Transfer strobe, incremented count and next LFSR value (taps 7,5,4,3).
  assign xfer      = valid & ready;
  assign cnt_inc   = vec_cnt + COUNT_W'(1);
  assign lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign state_dbg = state;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      mode_q  <= 1'b0;
      num_q   <= '0;
      lfsr    <= SEED_EFF;
      a       <= 1'b0;
      b       <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      vec_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_vec != '0) begin
              mode_q  <= mode;
              num_q   <= num_vec;
              vec_cnt <= '0;
              lfsr    <= SEED_EFF;
              // First pair: walk index 0, or the reloaded seed bits.
              a       <= mode ? SEED_EFF[7] : 1'b0;
              b       <= mode ? SEED_EFF[0] : 1'b0;
              valid   <= 1'b1;
              busy    <= 1'b1;
              state   <= S_RUN;
            end else begin
              // Empty sequence: acknowledge with a bare done pulse.
              done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // A transfer coinciding with abort is still counted.
          if (xfer) begin
            vec_cnt <= cnt_inc;
            lfsr    <= lfsr_nxt;
          end
          if (abort) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (xfer) begin
            if (cnt_inc == num_q) begin
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              // Walk pair k is {k[1],k[0]} where k is the transfers so far.
              a <= mode_q ? lfsr_nxt[7] : cnt_inc[1];
              b <= mode_q ? lfsr_nxt[0] : cnt_inc[0];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ab_stim_seq.sv
// tb_ab_stim_seq: scoreboard bench for ab_stim_seq. The driver pushes the
// expected {a,b} pairs of each sequence into exp_q; the negedge monitor
// checks every valid cycle against the queue head and pops on transfers.
module tb_ab_stim_seq;

  localparam int COUNT_W = 8;

  logic               clock;
  logic               reset_n;
  logic               start;
  logic               mode;
  logic [COUNT_W-1:0] num_vec;
  logic               abort;
  logic               ready;
  logic               a;
  logic               b;
  logic               valid;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] vec_cnt;
  logic [1:0]         state_dbg;

  ab_stim_seq #(.COUNT_W(COUNT_W), .LFSR_SEED(8'hA5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .mode      (mode),
    .num_vec   (num_vec),
    .abort     (abort),
    .ready     (ready),
    .a         (a),
    .b         (b),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .vec_cnt   (vec_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard state ----------------
  logic [1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int xfers = 0;       // transfers seen by the monitor, running total
  int seq_base = 0;    // xfers value at the start of the current sequence
  int seq_n = 0;       // programmed length of the current sequence
  int done_seen = 0;
  bit done_due = 1'b0;
  bit mon_en = 1'b0;
  bit zero_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pair sequence computed directly from the rules.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  task automatic push_expected(input bit m, input int n);
    logic [7:0] l;
    l = 8'hA5;
    for (int k = 0; k < n; k++) begin
      if (m) begin
        exp_q.push_back({l[7], l[0]});
        l = lfsr_step(l);
      end else begin
        exp_q.push_back(2'((k / 2) % 2 * 2 + k % 2));
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset_n && mon_en) begin
      if (done) done_seen++;
      if (!zero_mode) begin
        check("done_pulse", {31'd0, done}, {31'd0, done_due});
        if (done) begin
          check("done_vec_cnt", {24'd0, vec_cnt}, seq_n);
          check("done_busy", {31'd0, busy}, 0);
        end
      end
      done_due = 1'b0;
      if (valid) begin
        check("run_busy", {31'd0, busy}, 1);
        check("run_vec_cnt", {24'd0, vec_cnt}, xfers - seq_base);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'd0, valid}, 0);
        end else begin
          check("pair", {30'd0, a, b}, {30'd0, exp_q[0]});
          if (ready) begin
            void'(exp_q.pop_front());
            xfers++;
            if (xfers - seq_base == seq_n && !abort) done_due = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_seq(input bit m, input int n);
    push_expected(m, n);
    seq_n    = n;
    seq_base = xfers;
    start    = 1'b1;
    mode     = m;
    num_vec  = COUNT_W'(n);
    tick();
    start    = 1'b0;
    // Scramble inputs: the latched values must be what the DUT uses.
    mode     = 1'($urandom_range(0, 1));
    num_vec  = COUNT_W'($urandom_range(0, 255));
  endtask

  // stall: 0 = always ready, 1 = random ready, 2 = ready toggling 0/1.
  task automatic run_seq(input bit m, input int n, input int stall,
                         input int abort_at, input bit inject_start);
    int d0;
    int cyc;
    bit aborted;
    d0 = done_seen;
    aborted = 1'b0;
    start_seq(m, n);
    cyc = 0;
    while (cyc < 800) begin
      if (exp_q.size() == 0) break;
      if (abort_at >= 0 && xfers - seq_base == abort_at) begin
        ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        aborted = 1'b1;
        break;
      end
      case (stall)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(0, 1));
        default: ready = cyc[0];
      endcase
      if (inject_start && cyc == 2) begin
        start   = 1'b1;
        num_vec = COUNT_W'(2);
      end else begin
        start   = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    ready = 1'b0;
    if (cyc >= 800) check("seq_timeout", cyc, 0);
    if (aborted) begin
      check("abort_valid", {31'd0, valid}, 0);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_vec_cnt", {24'd0, vec_cnt}, abort_at);
      tick(); tick(); tick();
      check("abort_no_done", done_seen - d0, 0);
      exp_q.delete();
    end else begin
      tick(); tick(); tick();
      check("seq_done_count", done_seen - d0, 1);
      check("seq_final_cnt", {24'd0, vec_cnt}, n);
      check("seq_idle_valid", {31'd0, valid}, 0);
      check("seq_idle_busy", {31'd0, busy}, 0);
    end
  endtask

  task automatic zero_seq();
    int d0;
    d0 = done_seen;
    zero_mode = 1'b1;
    start_seq(1'b0, 0);
    check("zero_done", {31'd0, done}, 1);
    check("zero_valid", {31'd0, valid}, 0);
    check("zero_busy", {31'd0, busy}, 0);
    tick();
    check("zero_done_one_cycle", {31'd0, done}, 0);
    check("zero_valid_after", {31'd0, valid}, 0);
    tick();
    check("zero_busy_after", {31'd0, busy}, 0);
    check("zero_done_seen", done_seen - d0, 1);
    zero_mode = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a"},       {31'd0, a}, 0);
    check({tag, "_b"},       {31'd0, b}, 0);
    check({tag, "_valid"},   {31'd0, valid}, 0);
    check({tag, "_busy"},    {31'd0, busy}, 0);
    check({tag, "_done"},    {31'd0, done}, 0);
    check({tag, "_vec_cnt"}, {24'd0, vec_cnt}, 0);
  endtask

  task automatic reset_mid_run();
    start_seq(1'b0, 20);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    mon_en = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    check("async_reset_state", {30'd0, state_dbg}, 0);
    exp_q.delete();
    ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_valid", {31'd0, valid}, 0);
      check("post_reset_busy", {31'd0, busy}, 0);
    end
    mon_en = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    mode    = 1'b0;
    num_vec = '0;
    abort   = 1'b0;
    ready   = 1'b0;
    #2;
    check_reset_outputs("reset");
    check("reset_state", {30'd0, state_dbg}, 0);
    tick(); tick();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick();

    run_seq(1'b0, 6, 0, -1, 1'b0);     // walk, no stall
    run_seq(1'b1, 3, 2, -1, 1'b0);     // LFSR, toggling ready
    zero_seq();                        // empty sequence
    run_seq(1'b0, 10, 1, 4, 1'b0);     // abort after 4 transfers
    run_seq(1'b0, 4, 0, -1, 1'b0);     // restart after abort begins at 00
    run_seq(1'b0, 5, 0, -1, 1'b1);     // start during RUN is ignored
    run_seq(1'b1, 12, 1, 0, 1'b0);     // abort before any transfer
    run_seq(1'b0, 255, 0, -1, 1'b0);   // maximum count
    reset_mid_run();
    for (int i = 0; i < 6; i++) begin
      run_seq(1'($urandom_range(0, 1)), $urandom_range(1, 20),
              $urandom_range(0, 1), -1, 1'b0);
    end
    run_seq(1'b1, 9, 1, -1, 1'b0);     // LFSR again, reseeded from A5

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
